io_read_arbiter: RTL and testbench

IO_READ_ARBITER -- requirements
Module: io_read_arbiter

---
 rtl/io_read_arbiter.sv | 90 +++++++++
 tb/tb_io_read_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/io_read_arbiter.sv
// Round-robin arbiter that funnels several word sources into one Octavo I/O read
// port through a single-entry buffer, one word per cycle when the CPU keeps reading.
//   state | meaning
//   EMPTY | no word held, io_read_EF low
//   FULL  | word held for the CPU, io_read_EF high
module io_read_arbiter #(
  parameter int WORD_WIDTH      = 36,
  parameter int REQUESTER_COUNT = 4,
  parameter int REQUESTER_WIDTH = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [REQUESTER_COUNT-1:0]            req_valid,
  input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_data,
  output logic [REQUESTER_COUNT-1:0]            req_ready,
  output logic                                  io_read_EF,
  output logic [WORD_WIDTH-1:0]                 io_read_data,
  input  logic                                  io_rden,
  output logic [REQUESTER_WIDTH-1:0]            grant_id,
  output logic                                  underflow
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [REQUESTER_WIDTH-1:0] LAST_ID = REQUESTER_WIDTH'(REQUESTER_COUNT - 1);

  state_t                     state, state_next;
  logic [REQUESTER_WIDTH-1:0] last_grant;
  logic [REQUESTER_WIDTH-1:0] winner;
  logic [REQUESTER_WIDTH-1:0] search_id;
  logic [WORD_WIDTH-1:0]      winner_word;
  logic                       found;
  logic                       accept;

  // Walk one lap starting just after last_grant, wrapping at LAST_ID for any count.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    search_id = last_grant;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      search_id = (search_id == LAST_ID) ? '0 : search_id + 1'b1;
      if (!found && req_valid[search_id]) begin
        found  = 1'b1;
        winner = search_id;
      end
    end
  end

  always_comb begin
    winner_word = '0;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      if (winner == REQUESTER_WIDTH'(i)) winner_word = req_data[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = ((state == EMPTY) || io_rden) && found;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (io_rden && !accept) state_next = EMPTY;
    endcase
    if (accept && reset_n) req_ready = REQUESTER_COUNT'(1) << winner;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      io_read_data <= '0;
      grant_id     <= '0;
      last_grant   <= LAST_ID;
      underflow    <= 1'b0;
    end else begin
      if (accept) begin
        io_read_data <= winner_word;
        grant_id     <= winner;
        last_grant   <= winner;
      end
      if (io_rden && (state == EMPTY)) underflow <= 1'b1;
    end
  end

  assign io_read_EF = (state == FULL);

endmodule

// File: tb/tb_io_read_arbiter.sv
// Bench for io_read_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the buffer and round-robin pointer.
module tb_io_read_arbiter;
  localparam int N = 4;
  localparam int W = 36;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             io_read_EF;
  logic [W-1:0]     io_read_data;
  logic             io_rden;
  logic [1:0]       grant_id;
  logic             underflow;

  int n_asserts = 0;
  int n_fails   = 0;

  // model state
  bit           m_full;
  logic [W-1:0] m_data;
  int           m_grant;
  int           m_last;
  bit           m_uf;

  io_read_arbiter #(.WORD_WIDTH(W), .REQUESTER_COUNT(N), .REQUESTER_WIDTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .io_read_EF(io_read_EF), .io_read_data(io_read_data),
    .io_rden(io_rden), .grant_id(grant_id), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit model_accept();
    return (!m_full || io_rden) && (req_valid != '0);
  endfunction

  // Check all outputs at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    int w;
    @(negedge clock);
    exp_ready = '0;
    if (reset_n && model_accept()) exp_ready[pick_winner()] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("io_read_EF", 64'(io_read_EF), 64'(m_full));
    check("io_read_data", 64'(io_read_data), 64'(m_data));
    check("grant_id", 64'(grant_id), 64'(m_grant));
    check("underflow", 64'(underflow), 64'(m_uf));
    @(posedge clock);
    if (!reset_n) begin
      m_full = 0; m_data = '0; m_grant = 0; m_last = N - 1; m_uf = 0;
    end else begin
      if (io_rden && !m_full) m_uf = 1;
      if (model_accept()) begin
        w = pick_winner();
        m_full = 1; m_data = req_data[w*W +: W]; m_grant = w; m_last = w;
      end else if (io_rden && m_full) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit rst, input logic [N-1:0] valid, input bit rden);
    reset_n = rst; req_valid = valid; io_rden = rden;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {4'($urandom), 32'($urandom)};
  endtask

  initial begin
    m_full = 0; m_data = '0; m_grant = 0; m_last = N - 1; m_uf = 0;
    req_data = '0;
    drive(0, '0, 0);
    cycle(); cycle();

    // single request
    rand_data();
    req_data[0 +: W] = 36'h123;
    drive(1, 4'b0001, 0);
    cycle();
    check("single_ef", 64'(io_read_EF), 64'd1);
    check("single_data", 64'(io_read_data), 64'h123);
    check("single_gid", 64'(grant_id), 64'd0);

    // round-robin with sustained reads
    drive(0, '0, 0); cycle();
    drive(1, 4'b1111, 0); cycle();
    check("rr_gid0", 64'(grant_id), 64'd0);
    io_rden = 1;
    for (int k = 1; k <= 4; k++) begin
      rand_data();
      cycle();
      check($sformatf("rr_gid%0d", k), 64'(grant_id), 64'(k % 4));
      check("rr_ef", 64'(io_read_EF), 64'd1);
    end

    // backpressure
    drive(1, 4'b0010, 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_data", 64'(io_read_data), 64'(m_data));
    end
    io_rden = 1;
    cycle();
    check("bp_accept_gid", 64'(grant_id), 64'd1);

    // underflow
    drive(0, '0, 0); cycle();
    drive(1, '0, 1); cycle();
    check("uf_set", 64'(underflow), 64'd1);
    check("uf_ef", 64'(io_read_EF), 64'd0);
    io_rden = 0; cycle();
    check("uf_held", 64'(underflow), 64'd1);

    // reset mid-operation
    drive(0, '0, 0); cycle();
    req_data[2*W +: W] = 36'h55;
    drive(1, 4'b0100, 0); cycle();
    check("mid_data_loaded", 64'(io_read_data), 64'h55);
    drive(0, 4'b1111, 1); cycle();
    check("mid_ef", 64'(io_read_EF), 64'd0);
    check("mid_data", 64'(io_read_data), 64'd0);
    drive(1, 4'b1111, 0); cycle();
    check("mid_first_gid", 64'(grant_id), 64'd0);

    // skip idle requesters
    drive(0, '0, 0); cycle();
    drive(1, 4'b0010, 0); cycle();
    check("skip_setup", 64'(grant_id), 64'd1);
    drive(1, 4'b1001, 1); cycle();
    check("skip_first", 64'(grant_id), 64'd3);
    cycle();
    check("skip_second", 64'(grant_id), 64'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      rand_data();
      drive(($urandom_range(0, 49) != 0), 4'($urandom), ($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
